mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a synchronous RAM and an LED register.
// Each grant is a fixed three-cycle transaction: IDLE (grant) -> ACCESS -> RESP (ack).
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          p0_req,
  input  logic          p1_req,
  input  logic          p0_we,
  input  logic          p1_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic [DW-1:0] p1_wdata,
  output logic          p0_ack,
  output logic          p1_ack,
  output logic [DW-1:0] p0_rdata,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_q,
  output logic          led_wr,
  output logic [DW-1:0] led_data,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_owner;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;

  logic            w_grant;
  logic            w_sel;
  logic [3:0]      w_region;
  logic            w_access;
  logic            w_resp;
  logic [DW-1:0]   w_rdata;

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_sel        = r_owner;
    case (r_state)
      IDLE: begin
        if (p0_req || p1_req) begin
          w_grant      = 1'b1;
          // On a tie the requester that did not win last time goes first.
          w_sel        = (p0_req && p1_req) ? ~r_owner : p1_req;
          w_state_next = ACCESS;
        end
      end
      ACCESS:  w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_state <= IDLE;
      r_owner <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_owner <= w_sel;
        r_we    <= w_sel ? p1_we    : p0_we;
        r_addr  <= w_sel ? p1_addr  : p0_addr;
        r_wdata <= w_sel ? p1_wdata : p0_wdata;
      end
    end
  end

  // Strobes are qualified by Resetn so a reset landing mid-transaction writes and acks nothing.
  assign w_region = r_addr[AW-1:AW-4];
  assign w_access = (r_state == ACCESS) && Resetn;
  assign w_resp   = (r_state == RESP) && Resetn;

  assign mem_addr = r_addr;
  assign mem_data = r_wdata;
  assign mem_wren = w_access && r_we && (w_region == 4'h0);
  assign led_wr   = w_access && r_we && (w_region == 4'h1);
  assign led_data = r_wdata;

  assign w_rdata  = (w_resp && !r_we && (w_region == 4'h0)) ? mem_q : '0;
  assign p0_ack   = w_resp && !r_owner;
  assign p1_ack   = w_resp && r_owner;
  assign p0_rdata = r_owner ? '0 : w_rdata;
  assign p1_rdata = r_owner ? w_rdata : '0;

  assign busy  = (r_state != IDLE);
  assign owner = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model with per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic and resets.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          Clock = 1'b0;
  logic          Resetn = 1'b0;
  logic          p0_req = 1'b0, p1_req = 1'b0;
  logic          p0_we = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_ack, p1_ack;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_wren;
  logic [DW-1:0] mem_q;
  logic          led_wr;
  logic [DW-1:0] led_data;
  logic          busy, owner;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clock = ~Clock;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_ack(p0_ack), .p1_ack(p1_ack), .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
    .led_wr(led_wr), .led_data(led_data), .busy(busy), .owner(owner)
  );

  // Synchronous RAM behind the arbiter (region 0 is 4K words).
  logic [DW-1:0] ram [0:4095];
  always @(posedge Clock) begin
    if (mem_wren === 1'b1) ram[mem_addr[11:0]] <= mem_data;
    mem_q <= ram[mem_addr[11:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction stamped with the edge it was granted on.
  int            cyc = 0;
  bit            m_valid = 0;
  bit            m_act = 0;
  logic          m_owner = 1'b1;
  int            m_g = 0;
  int            m_next = 0;
  logic          m_sel = 1'b0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] mmem [0:4095];

  always @(posedge Clock) begin
    cyc = cyc + 1;
    if (!Resetn) begin
      m_valid = 1;
      m_act   = 0;
      m_owner = 1'b1;
      m_next  = 0;
    end else begin
      if (m_act && cyc == m_g + 1 && m_we && m_addr[15:12] == 4'h0)
        mmem[m_addr[11:0]] = m_wdata;
      if (m_act && cyc >= m_g + 2) m_act = 0;
      if (m_valid && !m_act && cyc >= m_next && (p0_req || p1_req)) begin
        if (p0_req && p1_req) m_sel = (m_owner == 1'b1) ? 1'b0 : 1'b1;
        else                  m_sel = p1_req;
        m_owner = m_sel;
        m_we    = m_sel ? p1_we    : p0_we;
        m_addr  = m_sel ? p1_addr  : p0_addr;
        m_wdata = m_sel ? p1_wdata : p0_wdata;
        m_act   = 1;
        m_g     = cyc;
        m_next  = cyc + 3;
      end
    end
  end

  bit            c_acc, c_rsp, c_reg0, c_reg1, e_wren, e_led, e_ack0, e_ack1;
  logic [DW-1:0] e_rd;

  always @(negedge Clock) begin
    if (m_valid) begin
      c_acc  = m_act && (cyc == m_g);
      c_rsp  = m_act && (cyc == m_g + 1);
      c_reg0 = (m_addr[15:12] == 4'h0);
      c_reg1 = (m_addr[15:12] == 4'h1);
      e_wren = c_acc && Resetn && m_we && c_reg0;
      e_led  = c_acc && Resetn && m_we && c_reg1;
      e_ack0 = c_rsp && Resetn && !m_sel;
      e_ack1 = c_rsp && Resetn && m_sel;
      e_rd   = (!m_we && c_reg0) ? mmem[m_addr[11:0]] : '0;
      chk("busy", busy, c_acc || c_rsp);
      chk("owner", owner, m_owner);
      chk("p0_ack", p0_ack, e_ack0);
      chk("p1_ack", p1_ack, e_ack1);
      chk("mem_wren", mem_wren, e_wren);
      chk("led_wr", led_wr, e_led);
      if (!(e_ack0 && m_we)) chk("p0_rdata", p0_rdata, e_ack0 ? e_rd : '0);
      if (!(e_ack1 && m_we)) chk("p1_rdata", p1_rdata, e_ack1 ? e_rd : '0);
      if (c_acc) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_data", mem_data, m_wdata);
      end
      if (e_led) chk("led_data", led_data, m_wdata);
      if (e_ack0 || e_ack1)
        $display("txn p%0d %s addr=%h wdata=%h rdata=%h", m_sel, m_we ? "wr" : "rd",
                 m_addr, m_wdata, m_sel ? p1_rdata : p0_rdata);
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  int            seq [0:15];
  int            n_acks;
  logic [DW-1:0] rd_seq [0:15];
  logic [3:0]    regions [0:4];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]  = '0;
      mmem[i] = '0;
    end
    ram[5]  = 16'h1234;
    mmem[5] = 16'h1234;
    regions[0] = 4'h0; regions[1] = 4'h0; regions[2] = 4'h1;
    regions[3] = 4'h2; regions[4] = 4'hF;

    // Reset values
    Resetn = 1'b0;
    repeat (3) tick();
    chk("rst_p0_ack", p0_ack, 1'b0);
    chk("rst_p1_ack", p1_ack, 1'b0);
    chk("rst_p0_rdata", p0_rdata, 16'h0);
    chk("rst_p1_rdata", p1_rdata, 16'h0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_data", mem_data, 16'h0);
    chk("rst_mem_wren", mem_wren, 1'b0);
    chk("rst_led_wr", led_wr, 1'b0);
    chk("rst_led_data", led_data, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 1'b1);
    Resetn = 1'b1;

    // Single p0 read with fixed two-cycle latency
    p0_req = 1; p0_we = 0; p0_addr = 16'h0005;
    tick();
    p0_req = 0;
    chk("rd5_early_ack", p0_ack, 1'b0);
    tick();
    chk("rd5_p0_ack", p0_ack, 1'b1);
    chk("rd5_p0_rdata", p0_rdata, 16'h1234);
    chk("rd5_p1_ack", p1_ack, 1'b0);
    tick();

    // Tie after reset: p0 first (old data), then p1 write, then p0 sees new data
    Resetn = 0; repeat (2) tick(); Resetn = 1;
    p1_req = 1; p1_we = 1; p1_addr = 16'h0003; p1_wdata = 16'hBEEF;
    p0_req = 1; p0_we = 0; p0_addr = 16'h0003;
    tick();
    p0_req = 0;
    chk("tie_owner0", owner, 1'b0);
    tick();
    chk("tie_p0_ack", p0_ack, 1'b1);
    chk("tie_p0_old", p0_rdata, 16'h0000);
    tick();
    tick();
    p1_req = 0;
    chk("tie_owner1", owner, 1'b1);
    tick();
    chk("tie_p1_ack", p1_ack, 1'b1);
    tick();
    p0_req = 1; p0_we = 0; p0_addr = 16'h0003;
    tick();
    p0_req = 0;
    tick();
    chk("tie_p0_new", p0_rdata, 16'hBEEF);
    tick();

    // Both held high: grants alternate p0, p1, ... one ack per three cycles
    Resetn = 0;
    p0_req = 1; p0_we = 0; p0_addr = 16'h0005;
    p1_req = 1; p1_we = 0; p1_addr = 16'h0003;
    repeat (2) tick();
    Resetn = 1;
    n_acks = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if ((p0_ack || p1_ack) && n_acks < 16) begin
        seq[n_acks]    = p1_ack ? 1 : 0;
        rd_seq[n_acks] = p1_ack ? p1_rdata : p0_rdata;
        n_acks++;
      end
    end
    p0_req = 0; p1_req = 0;
    chk("rr_ack_count", n_acks, 4);
    for (int k = 0; k < 4; k++) begin
      chk("rr_order", seq[k], k % 2);
      chk("rr_rdata", rd_seq[k], (k % 2 == 0) ? 16'h1234 : 16'hBEEF);
    end
    tick(); tick();

    // LED write and unmapped read
    p1_req = 1; p1_we = 1; p1_addr = 16'h1000; p1_wdata = 16'h00A5;
    tick();
    p1_req = 0;
    chk("led_wr", led_wr, 1'b1);
    chk("led_data", led_data, 16'h00A5);
    chk("led_mem_wren", mem_wren, 1'b0);
    tick();
    chk("led_p1_ack", p1_ack, 1'b1);
    tick();
    p1_req = 1; p1_we = 0; p1_addr = 16'h2000;
    tick();
    p1_req = 0;
    tick();
    chk("unmap_p1_ack", p1_ack, 1'b1);
    chk("unmap_p1_rdata", p1_rdata, 16'h0000);
    tick();

    // Reset during ACCESS of a p0 write aborts it
    p0_req = 1; p0_we = 1; p0_addr = 16'h0004; p0_wdata = 16'h5555;
    tick();
    p0_req = 0;
    Resetn = 0;
    #1;
    chk("abort_mem_wren", mem_wren, 1'b0);
    tick();
    chk("abort_busy", busy, 1'b0);
    chk("abort_owner", owner, 1'b1);
    chk("abort_p0_ack", p0_ack, 1'b0);
    Resetn = 1;
    tick();
    chk("abort_p0_ack2", p0_ack, 1'b0);
    chk("abort_ram4", ram[4], 16'h0000);
    tick();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      Resetn   = ($urandom_range(0, 79) != 0);
      p0_req   = ($urandom_range(0, 2) != 0);
      p1_req   = ($urandom_range(0, 2) != 0);
      p0_we    = $urandom_range(0, 1);
      p1_we    = $urandom_range(0, 1);
      p0_addr  = {regions[$urandom_range(0, 4)], 8'h00, 4'($urandom_range(0, 15))};
      p1_addr  = {regions[$urandom_range(0, 4)], 8'h00, 4'($urandom_range(0, 15))};
      p0_wdata = 16'($urandom);
      p1_wdata = 16'($urandom);
      tick();
    end
    Resetn = 1; p0_req = 0; p1_req = 0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
